// File: rtl/juego_move_scheduler_if.sv
// Button/handshake bundle between the board, the move scheduler and the game FSM.
// The scheduler uses the slave view; the board/game side uses the master view.
interface juego_move_scheduler_if #(
    parameter int unsigned MOVE_W = 8
);
    logic [3:0]        btn_req;
    logic              start;
    logic              game_over;
    logic              move_done;
    logic [2:0]        move_code;
    logic              move_valid;
    logic              busy;
    logic [MOVE_W-1:0] move_count;
    logic              timeout_err;
    logic [2:0]        state;

    modport master (
        output btn_req, start, game_over, move_done,
        input  move_code, move_valid, busy, move_count, timeout_err, state
    );

    modport slave (
        input  btn_req, start, game_over, move_done,
        output move_code, move_valid, busy, move_count, timeout_err, state
    );
endinterface

// File: rtl/juego_move_scheduler.sv
// Debounces and round-robin arbitrates the direction buttons, then issues one move code
// per press to the game FSM over a valid/done handshake with timeout and new-game control.
module juego_move_scheduler #(
    parameter int unsigned HOLD_CYCLES = 4,
    parameter int unsigned TIMEOUT     = 16,
    parameter int unsigned MOVE_W      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    juego_move_scheduler_if.slave bus
);

    localparam int unsigned DB_W = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
    localparam int unsigned TO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(HOLD_CYCLES - 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    localparam logic [2:0] CODE_NONE = 3'b000;
    localparam logic [2:0] CODE_NEWG = 3'b101;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_NEWG     = 3'd1,
        S_ARMED    = 3'd2,
        S_ISSUE    = 3'd3,
        S_WAIT_REL = 3'd4,
        S_OVER     = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        snap_q, snap_d;
    logic [DB_W-1:0]   db_q, db_d;
    logic [TO_W-1:0]   to_q, to_d;
    logic [1:0]        rr_q, rr_d;
    logic [2:0]        code_q, code_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;
    logic [MOVE_W-1:0] count_q, count_d;
    logic              terr_q, terr_d;

    logic [1:0]        grant_idx;
    logic              btn_match;

    // Round-robin pick: first requesting button at or after rr_q, wrapping 3->0
    always_comb begin
        logic       found;
        logic [1:0] cand;
        found     = 1'b0;
        grant_idx = rr_q;
        cand      = rr_q;
        for (int i = 0; i < 4; i++) begin
            cand = rr_q + 2'(i);
            if (!found && bus.btn_req[cand]) begin
                found     = 1'b1;
                grant_idx = cand;
            end
        end
    end

    assign btn_match = (bus.btn_req == snap_q) && (bus.btn_req != 4'd0);

    // Next-state and next-output logic
    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        db_d    = db_q;
        to_d    = to_q;
        rr_d    = rr_q;
        code_d  = code_q;
        count_d = count_q;
        terr_d  = terr_q;

        unique case (state_q)
            S_IDLE, S_OVER: begin
                if (bus.start) begin
                    state_d = S_NEWG;
                    code_d  = CODE_NEWG;
                    to_d    = '0;
                end
            end
            S_NEWG: begin
                if (bus.move_done) begin
                    count_d = '0;
                    terr_d  = 1'b0;
                    code_d  = CODE_NONE;
                    state_d = S_WAIT_REL;
                end else if (to_q == TO_LAST) begin
                    terr_d  = 1'b1;
                    code_d  = CODE_NONE;
                    state_d = S_IDLE;
                end else begin
                    to_d = to_q + TO_W'(1);
                end
            end
            S_ARMED: begin
                if (bus.game_over) begin
                    state_d = S_OVER;
                end else if (!btn_match) begin
                    snap_d = bus.btn_req;
                    db_d   = '0;
                end else if (db_q == DB_LAST) begin
                    rr_d    = grant_idx + 2'd1;
                    code_d  = {1'b0, grant_idx} + 3'd1;
                    db_d    = '0;
                    to_d    = '0;
                    state_d = S_ISSUE;
                end else begin
                    db_d = db_q + DB_W'(1);
                end
            end
            S_ISSUE: begin
                // start and game_over are deliberately not looked at until the handshake ends
                if (bus.move_done) begin
                    if (count_q != '1) begin
                        count_d = count_q + MOVE_W'(1);
                    end
                    code_d  = CODE_NONE;
                    state_d = S_WAIT_REL;
                end else if (to_q == TO_LAST) begin
                    terr_d  = 1'b1;
                    code_d  = CODE_NONE;
                    state_d = S_WAIT_REL;
                end else begin
                    to_d = to_q + TO_W'(1);
                end
            end
            S_WAIT_REL: begin
                if (bus.game_over) begin
                    state_d = S_OVER;
                end else if (bus.btn_req == 4'd0) begin
                    snap_d  = 4'd0;
                    db_d    = '0;
                    state_d = S_ARMED;
                end
            end
            default: begin
                code_d  = CODE_NONE;
                state_d = S_IDLE;
            end
        endcase

        valid_d = (state_d == S_NEWG) || (state_d == S_ISSUE);
        busy_d  = (state_d == S_NEWG) || (state_d == S_ISSUE) || (state_d == S_WAIT_REL);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            snap_q  <= 4'd0;
            db_q    <= '0;
            to_q    <= '0;
            rr_q    <= 2'd0;
            code_q  <= CODE_NONE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            count_q <= '0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            snap_q  <= snap_d;
            db_q    <= db_d;
            to_q    <= to_d;
            rr_q    <= rr_d;
            code_q  <= code_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            count_q <= count_d;
            terr_q  <= terr_d;
        end
    end

    assign bus.move_code   = code_q;
    assign bus.move_valid  = valid_q;
    assign bus.busy        = busy_q;
    assign bus.move_count  = count_q;
    assign bus.timeout_err = terr_q;
    assign bus.state       = state_q;

endmodule

// File: tb/tb_juego_move_scheduler.sv
// Directed bench for juego_move_scheduler: expected move codes are queued by the stimulus
// and checked by a monitor on every rising move_valid; state/count/flags checked inline.
module tb_juego_move_scheduler;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    logic [2:0] exp_q[$];
    logic       prev_valid = 1'b0;
    logic [2:0] held_code  = 3'd0;

    juego_move_scheduler_if #(.MOVE_W(8)) bus();

    juego_move_scheduler #(
        .HOLD_CYCLES(4),
        .TIMEOUT(16),
        .MOVE_W(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic done_pulse();
        bus.move_done = 1'b1;
        step(1);
        bus.move_done = 1'b0;
    endtask

    // Full press from ARMED: hold 4 samples, grant on the 5th edge, ack, release
    task automatic press(input logic [3:0] b, input logic [2:0] code, input logic [7:0] cnt_after);
        exp_q.push_back(code);
        bus.btn_req = b;
        step(4);
        check("press_not_yet_valid", bus.move_valid, 1'b0);
        step(1);
        check("press_valid", bus.move_valid, 1'b1);
        check("press_state_issue", bus.state, 3'd3);
        done_pulse();
        check("press_count", bus.move_count, cnt_after);
        check("press_state_wait", bus.state, 3'd4);
        bus.btn_req = 4'd0;
        step(1);
        check("press_state_armed", bus.state, 3'd2);
    endtask

    // Scoreboard monitor: every rising move_valid must match the oldest queued code
    initial begin
        forever begin
            @(negedge clk);
            if (bus.move_valid && !prev_valid) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_issue: code %0d while none queued", bus.move_code);
                end else begin
                    logic [2:0] e;
                    e = exp_q.pop_front();
                    if (bus.move_code !== e) begin
                        n_err++;
                        $display("FAIL issue_code: got %0d expected %0d", bus.move_code, e);
                    end
                end
            end else if (bus.move_valid && prev_valid) begin
                n_vec++;
                if (bus.move_code !== held_code) begin
                    n_err++;
                    $display("FAIL code_stable: got %0d expected %0d", bus.move_code, held_code);
                end
            end
            prev_valid = bus.move_valid;
            held_code  = bus.move_code;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.btn_req   = 4'd0;
        bus.start     = 1'b0;
        bus.game_over = 1'b0;
        bus.move_done = 1'b0;
        rst           = 1'b1;

        // 1: reset, new game, release
        step(1);
        rst = 1'b0;
        check("rst_state", bus.state, 3'd0);
        check("rst_valid", bus.move_valid, 1'b0);
        check("rst_code", bus.move_code, 3'd0);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_count", bus.move_count, 8'd0);
        check("rst_terr", bus.timeout_err, 1'b0);
        exp_q.push_back(3'b101);
        bus.start = 1'b1;
        step(1);
        bus.start = 1'b0;
        check("newg_valid", bus.move_valid, 1'b1);
        check("newg_code", bus.move_code, 3'b101);
        check("newg_state", bus.state, 3'd1);
        check("newg_busy", bus.busy, 1'b1);
        done_pulse();
        check("newg_done_state", bus.state, 3'd4);
        check("newg_done_count", bus.move_count, 8'd0);
        check("newg_done_valid", bus.move_valid, 1'b0);
        check("wait_rel_busy", bus.busy, 1'b1);
        step(1);
        check("armed_state", bus.state, 3'd2);
        check("armed_busy", bus.busy, 1'b0);

        // 2: single down press, held buttons never re-issue
        exp_q.push_back(3'b010);
        bus.btn_req = 4'b0010;
        step(4);
        check("down_edge4_valid", bus.move_valid, 1'b0);
        step(1);
        check("down_edge5_valid", bus.move_valid, 1'b1);
        check("down_code", bus.move_code, 3'b010);
        step(1);
        done_pulse();
        check("down_count", bus.move_count, 8'd1);
        check("down_valid_drop", bus.move_valid, 1'b0);
        step(8);
        check("held_no_reissue_state", bus.state, 3'd4);
        check("held_no_reissue_valid", bus.move_valid, 1'b0);
        bus.btn_req = 4'd0;
        step(1);
        check("down_release_state", bus.state, 3'd2);

        // 3: up+down together alternate via round robin (pointer now after down)
        press(4'b0011, 3'b001, 8'd2);
        press(4'b0011, 3'b010, 8'd3);
        press(4'b0011, 3'b001, 8'd4);

        // 4: bouncing button never qualifies, then a stable left press does
        for (int k = 0; k < 4; k++) begin
            bus.btn_req = 4'b0100;
            step(2);
            bus.btn_req = 4'b0000;
            step(2);
        end
        check("bounce_valid", bus.move_valid, 1'b0);
        check("bounce_state", bus.state, 3'd2);
        press(4'b0100, 3'b011, 8'd5);

        // 5: right press with no ack times out after 16 valid cycles
        exp_q.push_back(3'b100);
        bus.btn_req = 4'b1000;
        step(5);
        check("to_valid_start", bus.move_valid, 1'b1);
        step(15);
        check("to_valid_cycle16", bus.move_valid, 1'b1);
        step(1);
        check("to_valid_drop", bus.move_valid, 1'b0);
        check("to_terr", bus.timeout_err, 1'b1);
        check("to_count", bus.move_count, 8'd5);
        check("to_state", bus.state, 3'd4);
        bus.btn_req = 4'd0;
        step(1);
        check("to_release_state", bus.state, 3'd2);

        // 6: game_over deferred until the move completes, then OVER and new game
        exp_q.push_back(3'b001);
        bus.btn_req = 4'b0001;
        step(5);
        check("go_issue_valid", bus.move_valid, 1'b1);
        bus.game_over = 1'b1;
        step(2);
        check("go_deferred_state", bus.state, 3'd3);
        done_pulse();
        check("go_done_count", bus.move_count, 8'd6);
        check("go_done_state", bus.state, 3'd4);
        step(1);
        check("go_over_state", bus.state, 3'd5);
        bus.game_over = 1'b0;
        bus.btn_req   = 4'b0010;
        step(6);
        check("over_ignores_btn", bus.state, 3'd5);
        bus.btn_req = 4'd0;
        exp_q.push_back(3'b101);
        bus.start = 1'b1;
        step(1);
        bus.start = 1'b0;
        check("restart_code", bus.move_code, 3'b101);
        check("restart_terr_kept", bus.timeout_err, 1'b1);
        done_pulse();
        check("restart_terr_clear", bus.timeout_err, 1'b0);
        check("restart_count_clear", bus.move_count, 8'd0);
        step(1);
        check("restart_armed", bus.state, 3'd2);

        // Reset in the middle of ISSUE drops valid on the next edge
        exp_q.push_back(3'b001);
        bus.btn_req = 4'b0001;
        step(5);
        check("rst_mid_valid_before", bus.move_valid, 1'b1);
        rst = 1'b1;
        step(1);
        rst         = 1'b0;
        bus.btn_req = 4'd0;
        check("rst_mid_valid", bus.move_valid, 1'b0);
        check("rst_mid_state", bus.state, 3'd0);
        check("rst_mid_code", bus.move_code, 3'd0);

        // New-game handshake timeout returns to IDLE with the error flag set
        exp_q.push_back(3'b101);
        bus.start = 1'b1;
        step(1);
        bus.start = 1'b0;
        step(15);
        check("newg_to_valid_cycle16", bus.move_valid, 1'b1);
        step(1);
        check("newg_to_valid", bus.move_valid, 1'b0);
        check("newg_to_state", bus.state, 3'd0);
        check("newg_to_terr", bus.timeout_err, 1'b1);

        step(3);
        check("queue_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
